drum_audio_tap: RTL and testbench

- Consumer side of a mesh node's output interface.
- Samples one node's displacement word (u, signed 2.16 fixed point) on each validOut pulse, decimates by a fixed ratio, and converts to 16-bit signed audio with saturation.
- Buffers converted samples in a small FIFO and presents them on a valid/ready stream to the audio codec path.
- Sits between the drum grid's tap node and the audio DAC serializer.

---
 rtl/drum_audio_tap.sv | 68 ++++++
 tb/tb_drum_audio_tap.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/drum_audio_tap.sv
// drum_audio_tap: decimates a mesh node's displacement, saturates it to 16-bit audio and streams it through a FWFT FIFO
module drum_audio_tap #(
    parameter int DECIM = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [17:0]                   u_in,
    input  logic                          u_valid_in,
    input  logic                          enable,
    output logic [15:0]                   audio_data,
    output logic                          audio_valid,
    input  logic                          audio_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [DROP_W-1:0]             drop_count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;
    logic [DW-1:0] dcnt;
    logic          capture, conv_vld, pop, full, wr, drop;
    logic [15:0]   conv_data, conv_next;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    always_comb begin
        capture = enable && u_valid_in && dcnt == DW'(DECIM - 1);
        conv_next = u_in[17:16] == 2'b01 ? 16'h7FFF : u_in[17:16] == 2'b10 ? 16'h8000 : u_in[16:1];
        audio_valid = count != '0;
        audio_data = audio_valid ? mem[rd_ptr] : 16'h0000;
        pop = audio_valid && audio_ready;
        full = count == CW'(FIFO_DEPTH);
        wr = conv_vld && (!full || pop);
        drop = conv_vld && full && !pop;
        fifo_count = count;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt <= '0;
            conv_vld <= 1'b0;
            conv_data <= 16'h0000;
        end else begin
            dcnt <= !enable ? '0 : capture ? '0 : u_valid_in ? dcnt + 1'b1 : dcnt;
            conv_vld <= capture;
            if (capture) conv_data <= conv_next;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            drop_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr) - CW'(pop);
            if (drop && !(&drop_count)) drop_count <= drop_count + 1'b1;
            overflow <= overflow | drop;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= conv_data;
    end
endmodule

// File: tb/tb_drum_audio_tap.sv
// tb_drum_audio_tap: directed vectors against a DECIM=4 and a DECIM=1 instance sharing one stimulus
module tb_drum_audio_tap;
    logic        clk = 1'b0, reset = 1'b1;
    logic [17:0] u_in = '0;
    logic        u_valid_in = 1'b0, enable = 1'b1, audio_ready = 1'b0;
    logic [15:0] d4, d1;
    logic        v4, v1, o4, o1;
    logic [3:0]  c4, c1;
    logic [7:0]  p4, p1;
    int          nvec = 0, nbad = 0;

    always #5 clk = ~clk;

    drum_audio_tap #(.DECIM(4), .FIFO_DEPTH(8), .DROP_W(8)) dut4 (
        .clk(clk), .reset(reset), .u_in(u_in), .u_valid_in(u_valid_in), .enable(enable),
        .audio_data(d4), .audio_valid(v4), .audio_ready(audio_ready),
        .fifo_count(c4), .drop_count(p4), .overflow(o4));

    drum_audio_tap #(.DECIM(1), .FIFO_DEPTH(8), .DROP_W(8)) dut1 (
        .clk(clk), .reset(reset), .u_in(u_in), .u_valid_in(u_valid_in), .enable(enable),
        .audio_data(d1), .audio_valid(v1), .audio_ready(audio_ready),
        .fifo_count(c1), .drop_count(p1), .overflow(o1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [17:0] v);
        u_in = v;
        u_valid_in = 1'b1;
        tick();
        u_valid_in = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [17:0] sat_in  [5] = '{18'h10000, 18'h0FFFF, 18'h30000, 18'h2FFFF, 18'h3FFFF};
    logic [15:0] sat_out [5] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'hFFFF};

    initial begin
        tick();
        do_reset();
        check("rst_valid4", v4, 0);
        check("rst_valid1", v1, 0);
        check("rst_data4", d4, 0);
        check("rst_count4", c4, 0);
        check("rst_drop4", p4, 0);
        check("rst_ovf4", o4, 0);

        // decimation by 4, pulses 5 cycles apart
        audio_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            pulse(18'(k * 'h100));
            check($sformatf("dec_conv_k%0d", k), v4, 0);
            tick();
            check($sformatf("dec_valid_k%0d", k), v4, (k % 4 == 0) ? 1 : 0);
            if (k % 4 == 0) check($sformatf("dec_data_k%0d", k), d4, (k == 4) ? 32'h0200 : 32'h0400);
            tick(); tick(); tick();
        end

        // saturation and format on DECIM=1
        do_reset();
        audio_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulse(sat_in[i]);
            tick();
            check($sformatf("sat_valid%0d", i), v1, 1);
            check($sformatf("sat_data%0d", i), d1, sat_out[i]);
            audio_ready = 1'b1;
            tick();
            audio_ready = 1'b0;
        end

        // back-pressure and overflow
        do_reset();
        u_valid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            u_in = 18'((i + 1) * 'h100);
            tick();
        end
        u_valid_in = 1'b0;
        tick(); tick();
        check("ovf_count", c1, 8);
        check("ovf_drop", p1, 2);
        check("ovf_flag", o1, 1);
        audio_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d", i), d1, 32'((i + 1) * 'h80));
            tick();
        end
        check("drain_valid", v1, 0);
        check("drain_count", c1, 0);
        check("drain_drop_kept", p1, 2);

        // full with simultaneous pop
        do_reset();
        audio_ready = 1'b0;
        u_valid_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            u_in = 18'((i + 1) * 'h100);
            tick();
        end
        u_valid_in = 1'b0;
        tick();
        check("fullpop_pre", c1, 8);
        pulse(18'h00900);
        audio_ready = 1'b1;
        tick();
        audio_ready = 1'b0;
        check("fullpop_count", c1, 8);
        check("fullpop_drop", p1, 0);
        check("fullpop_ovf", o1, 0);
        check("fullpop_head", d1, 16'h0100);

        // enable gating on DECIM=4
        do_reset();
        audio_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) begin
                enable = 1'b0;
                tick();
                enable = 1'b1;
                continue;
            end
            pulse(18'(k * 'h100));
            tick();
            check($sformatf("en_valid_k%0d", k), v4, (k == 8) ? 1 : 0);
            if (k == 8) check("en_data", d4, 16'h0400);
            tick();
        end

        // reset mid-operation
        do_reset();
        audio_ready = 1'b0;
        for (int i = 0; i < 3; i++) pulse(18'h00200);
        tick(); tick();
        check("mid_count", c1, 3);
        check("mid_valid", v1, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", v1, 0);
        check("mid_rst_count", c1, 0);
        check("mid_rst_drop", p1, 0);
        check("mid_rst_ovf", o1, 0);
        check("mid_rst_data", d1, 0);
        audio_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            pulse(18'(k * 'h400));
            tick();
            check($sformatf("mid_dcnt_k%0d", k), v4, (k == 4) ? 1 : 0);
            if (k == 4) check("mid_dcnt_data", d4, 16'h0800);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
